// File: rtl/cache_line_engine_if.sv
// Bus bundle for cache_line_engine: command/ack FIFO pair, data-array port, memory port.
// master = engine side (pops commands, drives array and memory), slave = environment side.
interface cache_line_engine_if #(
   parameter int NUM_WAYS  = 1,
   parameter int NUM_LINES = 512,
   parameter int LINE_SIZE = 16,
   parameter int W_D       = 32,
   parameter int W_A       = 27
);
   localparam int W_WAY     = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
   localparam int WPL       = LINE_SIZE / (W_D / 8);
   localparam int W_LOCAL_A = $clog2(NUM_LINES * WPL);

   logic [31:0]          cmd_q;
   logic                 cmd_empty;
   logic                 cmd_deq;

   logic [31:0]          ack_d;
   logic                 ack_enq;
   logic                 ack_full;

   logic [W_WAY-1:0]     way_sel;
   logic [W_LOCAL_A-1:0] line_addr;
   logic [W_D-1:0]       line_d;
   logic                 line_we;
   logic [W_D-1:0]       line_q;

   logic [W_A-1:0]       mem_addr;
   logic                 mem_re;
   logic                 mem_we;
   logic [W_D-1:0]       mem_d;
   logic                 mem_ready;
   logic [W_D-1:0]       mem_rdata;
   logic                 mem_rvalid;

   modport master (
      input  cmd_q, cmd_empty, ack_full, line_q,
      input  mem_ready, mem_rdata, mem_rvalid,
      output cmd_deq, ack_d, ack_enq,
      output way_sel, line_addr, line_d, line_we,
      output mem_addr, mem_re, mem_we, mem_d
   );

   modport slave (
      output cmd_q, cmd_empty, ack_full, line_q,
      output mem_ready, mem_rdata, mem_rvalid,
      input  cmd_deq, ack_d, ack_enq,
      input  way_sel, line_addr, line_d, line_we,
      input  mem_addr, mem_re, mem_we, mem_d
   );
endinterface

// File: rtl/cache_line_engine.sv
// Cache miss/flush responder: pops command words, writes back victim line, fills new line, acks.
// Ports: CLK, RST_N (async low), bus (master modport of cache_line_engine_if), busy, err pulse.
module cache_line_engine #(
   parameter int NUM_WAYS  = 1,
   parameter int NUM_LINES = 512,
   parameter int LINE_SIZE = 16,
   parameter int W_D       = 32,
   parameter int W_A       = 27
) (
   input  logic                CLK,
   input  logic                RST_N,
   cache_line_engine_if.master bus,
   output logic                busy,
   output logic                err
);
   localparam int W_WAY     = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
   localparam int WPL       = LINE_SIZE / (W_D / 8);
   localparam int W_INDEX   = $clog2(NUM_LINES);
   localparam int W_LOCAL_A = $clog2(NUM_LINES * WPL);
   localparam int W_BO      = $clog2(W_D / 8);
   localparam int W_TAG     = W_A - W_LOCAL_A - W_BO;
   localparam int W_WC      = (WPL > 1) ? $clog2(WPL) : 1;

   typedef enum logic [3:0] {
      IDLE,
      GET_WAY,
      GET_IDX,
      GET_VTAG,
      GET_NTAG,
      WB_RD,
      WB_WR,
      FILL_REQ,
      FILL_WAIT,
      ACK
   } state_t;

   state_t               state;
   state_t               state_n;

   logic [1:0]           code_r;
   logic [W_WAY-1:0]     way_r;
   logic [W_INDEX-1:0]   idx_r;
   logic [W_TAG-1:0]     vtag_r;
   logic [W_TAG-1:0]     ntag_r;
   logic [W_WC-1:0]      wc;
   logic [W_D-1:0]       wdat;
   logic                 held;
   logic                 outstanding;
   logic                 rv_q;
   logic [W_D-1:0]       rd_q;
   logic                 live;

   logic                 pop;
   logic                 legal;
   logic                 last;
   logic                 acc_rd;
   logic [W_LOCAL_A-1:0] line_local;
   logic [W_TAG-1:0]     cur_tag;

   logic                 cmd_deq;
   logic                 ack_enq;
   logic                 line_we;
   logic                 mem_re;
   logic                 mem_we;
   logic                 err_c;

   // live holds fetches off until the first clock after reset release
   assign pop    = live && !bus.cmd_empty;
   assign legal  = (bus.cmd_q == 32'd1) ||
                   (bus.cmd_q == 32'd2) ||
                   (bus.cmd_q == 32'd3);
   assign last   = (wc == W_WC'(WPL - 1));
   assign acc_rd = (state == FILL_REQ) && bus.mem_ready;

   assign line_local = W_LOCAL_A'(idx_r) * W_LOCAL_A'(WPL)
                     + W_LOCAL_A'(wc);
   assign cur_tag    = (state == FILL_REQ) ? ntag_r : vtag_r;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) state <= IDLE;
      else        state <= state_n;
   end

   always_comb begin
      state_n = state;
      cmd_deq = 1'b0;
      ack_enq = 1'b0;
      line_we = 1'b0;
      mem_re  = 1'b0;
      mem_we  = 1'b0;
      err_c   = 1'b0;
      unique case (state)
         IDLE: begin
            if (pop) begin
               cmd_deq = 1'b1;
               if (legal) state_n = GET_WAY;
               else       err_c   = 1'b1;
            end
         end
         GET_WAY: begin
            if (pop) begin
               cmd_deq = 1'b1;
               state_n = GET_IDX;
            end
         end
         GET_IDX: begin
            if (pop) begin
               cmd_deq = 1'b1;
               state_n = (code_r == 2'd1) ? GET_NTAG : GET_VTAG;
            end
         end
         GET_VTAG: begin
            if (pop) begin
               cmd_deq = 1'b1;
               state_n = (code_r == 2'd2) ? GET_NTAG : WB_RD;
            end
         end
         GET_NTAG: begin
            if (pop) begin
               cmd_deq = 1'b1;
               state_n = (code_r == 2'd2) ? WB_RD : FILL_REQ;
            end
         end
         WB_RD: begin
            state_n = WB_WR;
         end
         WB_WR: begin
            mem_we = 1'b1;
            if (bus.mem_ready) begin
               if (!last)               state_n = WB_RD;
               else if (code_r == 2'd2) state_n = FILL_REQ;
               else                     state_n = ACK;
            end
         end
         FILL_REQ: begin
            mem_re = 1'b1;
            if (bus.mem_ready) state_n = FILL_WAIT;
         end
         FILL_WAIT: begin
            if (rv_q) begin
               line_we = 1'b1;
               state_n = last ? ACK : FILL_REQ;
            end
         end
         ACK: begin
            if (!bus.ack_full) begin
               ack_enq = 1'b1;
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         live        <= 1'b0;
         code_r      <= '0;
         way_r       <= '0;
         idx_r       <= '0;
         vtag_r      <= '0;
         ntag_r      <= '0;
         wc          <= '0;
         wdat        <= '0;
         held        <= 1'b0;
         outstanding <= 1'b0;
         rv_q        <= 1'b0;
         rd_q        <= '0;
      end else begin
         live <= 1'b1;

         if (pop) begin
            unique case (state)
               IDLE:     code_r <= bus.cmd_q[1:0];
               GET_WAY:  way_r  <= bus.cmd_q[W_WAY-1:0];
               GET_IDX:  idx_r  <= bus.cmd_q[W_INDEX-1:0];
               GET_VTAG: vtag_r <= bus.cmd_q[W_TAG-1:0];
               GET_NTAG: ntag_r <= bus.cmd_q[W_TAG-1:0];
               default:  ;
            endcase
         end

         if (state == IDLE) wc <= '0;

         if (state == WB_RD) held <= 1'b0;

         // line_q is only valid in the first WB_WR cycle; keep a copy for stalls
         if (state == WB_WR) begin
            if (!held) begin
               wdat <= bus.line_q;
               held <= 1'b1;
            end
            if (bus.mem_ready) wc <= last ? '0 : wc + W_WC'(1);
         end

         if ((state == FILL_WAIT) && rv_q) begin
            rv_q <= 1'b0;
            wc   <= last ? '0 : wc + W_WC'(1);
         end

         // rvalid may coincide with the accepting cycle; accept it only
         // for a read this engine issued, so stale returns after reset drop
         if (acc_rd || outstanding) begin
            if (bus.mem_rvalid) begin
               rv_q        <= 1'b1;
               rd_q        <= bus.mem_rdata;
               outstanding <= 1'b0;
            end else if (acc_rd) begin
               outstanding <= 1'b1;
            end
         end
      end
   end

   assign bus.cmd_deq   = cmd_deq;
   assign bus.ack_enq   = ack_enq;
   assign bus.ack_d     = 32'(code_r);
   assign bus.way_sel   = way_r;
   assign bus.line_addr = line_local;
   assign bus.line_d    = rd_q;
   assign bus.line_we   = line_we;
   assign bus.mem_re    = mem_re;
   assign bus.mem_we    = mem_we;
   assign bus.mem_addr  = W_A'({cur_tag, line_local}) << W_BO;
   assign bus.mem_d     = held ? wdat : bus.line_q;
   assign busy          = (state != IDLE);
   assign err           = err_c;
endmodule
